csr_matrix_encoder: RTL and testbench
=====================================

// Module: csr_matrix_encoder
// PURPOSE
//  Compresses a dense NxN weight matrix into a CSR entry stream for the sparse MVM accelerator.
//  Dense rows arrive one per handshake. Each non-zero element is emitted as a (row, col, value)
//  entry on a valid/ready stream, and the standard CSR row-pointer vector plus NNZ count is built.
//  It sits between the weight-load path and the CSR tables that feed the MVM engine.
// PARAMETERS
//  N  4                 matrix dimension (rows = cols = N), N >= 2
//  W  16                element value width, unsigned
//  CW $clog2(N)         row/column index width (derived)
//  PW $clog2(N*N+1)     row-pointer / NNZ count width (derived)
// PORTS
//  clk        in   1          clock, rising edge
//  rst        in   1          asynchronous, active-high reset
//  start      in   1          one-cycle pulse; begins a matrix frame when IDLE
//  busy       out  1          high from accepted start until done pulse (inclusive)
//  in_valid   in   1          dense row available
//  in_ready   out  1          encoder can accept a row
//  in_row     in   N*W        dense row; element c = in_row[c*W +: W]
//  out_valid  out  1          CSR entry valid
//  out_ready  in   1          downstream accepts entry
//  out_value  out  W          non-zero element value
//  out_col    out  CW         column index of entry
//  out_row    out  CW         row index of entry
//  nnz        out  PW         non-zeros emitted so far in current frame
//  row_ptr    out  (N+1)*PW   CSR pointers; row_ptr[r] = row_ptr[r*PW +: PW]
//  done       out  1          one-cycle pulse when the frame is complete
// BEHAVIOUR
//  Reset: state=IDLE; busy, in_ready, out_valid and done are 0; out_value/col/row, nnz and all row_ptr are 0.
//  FSM IDLE -> ACCEPT -> SCAN <-> EMIT -> (ACCEPT | FINISH) -> IDLE.
//  IDLE: start=1 clears nnz, row_ptr, row counter r and column counter c; next state ACCEPT.
//    busy=1 from the next cycle.
//  ACCEPT: in_ready=1, registered and driven only in this state. On in_valid&in_ready, latch in_row
//    into the row buffer, set c=0 and go to SCAN. in_ready drops in the cycle after the handshake.
//  SCAN: examines buffer element c, one element per cycle.
//    Zero element: advance c (see row end).
//    Non-zero element: register out_value=elem, out_col=c, out_row=r, set out_valid=1, go to EMIT.
//  EMIT: out_valid and out_* hold steady until out_ready. On out_valid&out_ready:
//    out_valid<=0; nnz<=nnz+1; advance c (see row end).
//    No new entry can appear in the same cycle as the handshake. Peak rate is 1 entry per 2 cycles.
//  Row end (c==N-1 advanced from SCAN or EMIT): row_ptr[r+1] <= nnz, counting row r's entries.
//    r==N-1 -> FINISH; otherwise r<=r+1 and go to ACCEPT.
//  FINISH: done=1 for exactly one cycle; busy=1 in that cycle; next IDLE with busy=0.
//    nnz and row_ptr hold until the next accepted start.
//  row_ptr[0] is always 0. row_ptr[N]==nnz after done. nnz max N*N fits PW, so no overflow.
//  Entries are emitted in row-major order with strictly increasing column within a row.
//  start while busy is ignored. in_valid outside ACCEPT is ignored; the source holds in_row until in_ready.
//  An all-zero row emits nothing; row_ptr[r+1]=row_ptr[r]; it takes N SCAN cycles.
//  rst mid-frame (any state, incl. EMIT with out_valid=1) aborts immediately to reset values;
//    no done pulse; the partial frame is discarded.
// TESTING
//  T1 Identity matrix (diag=1), out_ready=1 -> entries (0,0,1)(1,1,1)(2,2,1)(3,3,1); row_ptr=0,1,2,3,4; nnz=4; one done.
//  T2 All-zero matrix -> no out_valid ever; row_ptr all 0; nnz=0; done exactly 1 cycle; each row costs N SCAN cycles.
//  T3 Full matrix, values 1..16 row-major -> 16 entries in order; row_ptr=0,4,8,12,16; nnz=16.
//  T4 Backpressure: row0=[0,5,0,7], out_ready random ~30% -> out_* stable while stalled; entries (0,1,5),(0,3,7) once each; row_ptr[1]=2.
//  T5 start pulsed mid-frame and in_valid held high while in SCAN/EMIT -> ignored; frame result identical to T1; only 4 row handshakes.
//  T6 rst asserted in EMIT of row 2 -> same cycle async: out_valid=0, busy=0, nnz=0, row_ptr=0; new start then encodes T3 correctly.

Source files
------------

// File: rtl/csr_matrix_encoder.sv
// Dense-to-CSR encoder: takes one dense row per handshake and emits each non-zero as a
// (row, col, value) entry, while building the CSR row-pointer vector and the NNZ count.
module csr_matrix_encoder #(
    parameter int N  = 4,
    parameter int W  = 16,
    parameter int CW = $clog2(N),
    parameter int PW = $clog2(N*N+1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*W-1:0]      in_row,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W-1:0]        out_value,
    output logic [CW-1:0]       out_col,
    output logic [CW-1:0]       out_row,
    output logic [PW-1:0]       nnz,
    output logic [(N+1)*PW-1:0] row_ptr,
    output logic                done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ACCEPT = 3'd1;
    localparam logic [2:0] S_SCAN   = 3'd2;
    localparam logic [2:0] S_EMIT   = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [CW-1:0]       r_q, r_d, c_q, c_d;
    logic [N-1:0][W-1:0] buf_q, buf_d;
    logic                ov_q, ov_d;
    logic [W-1:0]        val_q, val_d;
    logic [CW-1:0]       col_q, col_d, row_q, row_d;
    logic [PW-1:0]       nnz_q, nnz_d;
    logic [N:0][PW-1:0]  rp_q, rp_d;

    logic [W-1:0]  elem;
    logic          last_col, last_row, adv;
    logic [PW-1:0] cnt;
    logic [CW:0]   rp_idx;

    assign elem     = buf_q[c_q];
    assign last_col = (c_q == CW'(N-1));
    assign last_row = (r_q == CW'(N-1));
    assign rp_idx   = {1'b0, r_q} + 1'b1;

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        buf_d   = buf_q;
        ov_d    = ov_q;
        val_d   = val_q;
        col_d   = col_q;
        row_d   = row_q;
        nnz_d   = nnz_q;
        rp_d    = rp_q;
        adv     = 1'b0;
        cnt     = nnz_q;
        case (state_q)
            S_IDLE: if (start) begin
                nnz_d   = '0;
                rp_d    = '0;
                r_d     = '0;
                c_d     = '0;
                state_d = S_ACCEPT;
            end
            S_ACCEPT: if (in_valid) begin
                buf_d   = in_row;
                c_d     = '0;
                state_d = S_SCAN;
            end
            S_SCAN: begin
                if (elem != '0) begin
                    val_d   = elem;
                    col_d   = c_q;
                    row_d   = r_q;
                    ov_d    = 1'b1;
                    state_d = S_EMIT;
                end else begin
                    adv = 1'b1;
                end
            end
            S_EMIT: if (out_ready) begin
                ov_d    = 1'b0;
                nnz_d   = nnz_q + PW'(1);
                cnt     = nnz_q + PW'(1);
                adv     = 1'b1;
                state_d = S_SCAN;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        // Column advance; at the last column the row is closed using the count including this entry.
        if (adv) begin
            if (last_col) begin
                rp_d[rp_idx] = cnt;
                if (last_row) begin
                    state_d = S_FINISH;
                end else begin
                    r_d     = r_q + CW'(1);
                    state_d = S_ACCEPT;
                end
            end else begin
                c_d = c_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            c_q     <= '0;
            buf_q   <= '0;
            ov_q    <= 1'b0;
            val_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            nnz_q   <= '0;
            rp_q    <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            buf_q   <= buf_d;
            ov_q    <= ov_d;
            val_q   <= val_d;
            col_q   <= col_d;
            row_q   <= row_d;
            nnz_q   <= nnz_d;
            rp_q    <= rp_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign in_ready  = (state_q == S_ACCEPT);
    assign done      = (state_q == S_FINISH);
    assign out_valid = ov_q;
    assign out_value = val_q;
    assign out_col   = col_q;
    assign out_row   = row_q;
    assign nnz       = nnz_q;
    assign row_ptr   = rp_q;

endmodule

// File: tb/tb_csr_matrix_encoder.sv
// Randomized bench for csr_matrix_encoder: a negedge driver/monitor feeds rows and records
// entries; each frame is compared with a CSR reference computed directly from the matrix.
module tb_csr_matrix_encoder;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int CW = $clog2(N);
    localparam int PW = $clog2(N*N+1);

    typedef struct packed {
        logic [CW-1:0] r;
        logic [CW-1:0] c;
        logic [W-1:0]  v;
    } ent_t;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start = 1'b0;
    logic                busy;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [N*W-1:0]      in_row = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [W-1:0]        out_value;
    logic [CW-1:0]       out_col;
    logic [CW-1:0]       out_row;
    logic [PW-1:0]       nnz;
    logic [(N+1)*PW-1:0] row_ptr;
    logic                done;

    csr_matrix_encoder #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
        .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
        .out_col(out_col), .out_row(out_row), .nnz(nnz), .row_ptr(row_ptr), .done(done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Stimulus configuration, written only by the main sequence.
    logic [W-1:0] mat [N][N];
    int           rdy_pct = 100;
    bit           force_v = 1'b0;

    // Observations, written only by the negedge driver/monitor.
    int   feed_idx   = N;
    bit   hs_pending = 1'b0;
    int   hs_cnt     = 0;
    int   done_cnt   = 0;
    int   busy_cyc   = 0;
    int   proto_err  = 0;
    ent_t ent_q[$];
    bit   prev_stall = 1'b0;
    ent_t prev_ent;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                feed_idx   = N;
                hs_pending = 1'b0;
                prev_stall = 1'b0;
                in_valid   = 1'b0;
            end else begin
                if (hs_pending) feed_idx++;
                if (start && !busy) feed_idx = 0;
                in_valid = (feed_idx < N) || force_v;
                for (int c = 0; c < N; c++) begin
                    if (feed_idx < N) in_row[c*W +: W] = mat[feed_idx][c];
                    else              in_row[c*W +: W] = W'($urandom);
                end
                hs_pending = in_valid && in_ready && (feed_idx < N);
                if (in_valid && in_ready) hs_cnt++;
                // A stalled entry must still be present and unchanged one cycle later.
                if (prev_stall && (!out_valid || prev_ent != {out_row, out_col, out_value}))
                    proto_err++;
                out_ready = ($urandom_range(99) < rdy_pct);
                if (out_valid && out_ready) ent_q.push_back({out_row, out_col, out_value});
                prev_stall = out_valid && !out_ready;
                prev_ent   = {out_row, out_col, out_value};
                if (done) begin
                    done_cnt++;
                    if (!busy) proto_err++;
                end
                if (busy) busy_cyc++;
            end
        end
    end

    task automatic run_frame(input string tag, input int pct, input bit fv, input bit mid_start);
        ent_t exp_q[$];
        int   exp_rp[N+1];
        int   h0, d0, b0, e0, p0, k;
        h0 = hs_cnt; d0 = done_cnt; b0 = busy_cyc; e0 = ent_q.size(); p0 = proto_err;
        rdy_pct = pct;
        force_v = fv;
        exp_rp[0] = 0;
        for (int r = 0; r < N; r++) begin
            exp_rp[r+1] = exp_rp[r];
            for (int c = 0; c < N; c++)
                if (mat[r][c] != 0) begin
                    exp_q.push_back({CW'(r), CW'(c), mat[r][c]});
                    exp_rp[r+1]++;
                end
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (done_cnt == d0 && k < 3000) begin
            @(posedge clk); #1;
            start = (mid_start && k == 7);
            k++;
        end
        start = 1'b0;
        chk({tag, "_timeout"}, (k >= 3000), 0);
        repeat (3) @(posedge clk);
        #1;
        force_v = 1'b0;
        chk({tag, "_done_cnt"}, done_cnt - d0, 1);
        chk({tag, "_row_hs"}, hs_cnt - h0, N);
        chk({tag, "_ent_cnt"}, ent_q.size() - e0, exp_q.size());
        for (int i = 0; i < exp_q.size() && e0 + i < ent_q.size(); i++)
            chk({tag, "_entry"}, ent_q[e0+i], exp_q[i]);
        chk({tag, "_nnz"}, nnz, exp_q.size());
        for (int r = 0; r <= N; r++)
            chk({tag, "_row_ptr"}, row_ptr[r*PW +: PW], exp_rp[r]);
        chk({tag, "_protocol"}, proto_err - p0, 0);
        chk({tag, "_idle"}, {busy, done, out_valid, in_ready}, 4'b0);
        // Without backpressure: one ACCEPT plus N SCAN cycles per row, one EMIT per entry, one FINISH.
        if (pct == 100)
            chk({tag, "_busy_cycles"}, busy_cyc - b0, N*(N+1) + exp_q.size() + 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctl"}, {busy, in_ready, out_valid, done}, 4'b0);
        chk({tag, "_out"}, {out_value, out_col, out_row}, '0);
        chk({tag, "_nnz"}, nnz, 0);
        chk({tag, "_row_ptr"}, row_ptr, '0);
    endtask

    initial begin
        int k;
        #1 rst = 1'b1;
        #2 check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // T1 identity
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) mat[r][c] = (r == c) ? 16'd1 : 16'd0;
        run_frame("t1_identity", 100, 1'b0, 1'b0);

        // T2 all zero
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) mat[r][c] = '0;
        run_frame("t2_zero", 100, 1'b0, 1'b0);

        // T3 full 1..16
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) mat[r][c] = W'(r*N + c + 1);
        run_frame("t3_full", 100, 1'b0, 1'b0);

        // T4 backpressure on a sparse first row
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) mat[r][c] = '0;
        mat[0][1] = 16'd5;
        mat[0][3] = 16'd7;
        run_frame("t4_backpressure", 30, 1'b0, 1'b0);

        // T5 spurious start and in_valid held high
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) mat[r][c] = (r == c) ? 16'd1 : 16'd0;
        run_frame("t5_spurious", 100, 1'b1, 1'b1);

        // T6 reset while an entry of row 2 is pending
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) mat[r][c] = W'(r*N + c + 1);
        rdy_pct = 50;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (!(out_valid && out_row == 2) && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        chk("t6_reach_row2", (k >= 2000), 0);
        rst = 1'b1;
        #1 check_reset_outputs("t6_abort");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_frame("t6_restart", 100, 1'b0, 1'b0);

        // Random matrices with varying density and backpressure
        for (int t = 0; t < 8; t++) begin
            int dens;
            dens = $urandom_range(90, 10);
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    mat[r][c] = ($urandom_range(99) < dens) ? W'($urandom_range(65535, 1)) : '0;
            run_frame("rand", (t % 3 == 0) ? 100 : $urandom_range(80, 20), t[0], 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
